// File: rtl/sdram_pkg.sv
// Shared constants, FSM encoding and pointer helper for the SDRAM burst writer.
package sdram_pkg;

  localparam int ADDR_W    = 24;
  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 4;

  localparam logic [1:0] REQ_NONE  = 2'b00;
  localparam logic [1:0] REQ_READ  = 2'b01;
  localparam logic [1:0] REQ_WRITE = 2'b10;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_BURST  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BURST,
    ST_SINGLE,
    ST_GAP,
    ST_FDONE
  } wr_state_e;

  typedef logic [BURST_LEN-1:0][DATA_W-1:0] burst_t;

  // Ring-pointer add: returns {wrapped, next_ptr}; anything past the last word restarts at base.
  function automatic logic [ADDR_W:0] ptr_add(input logic [ADDR_W-1:0] ptr,
                                              input logic [ADDR_W:0]   inc,
                                              input logic [ADDR_W-1:0] base,
                                              input logic [ADDR_W-1:0] last);
    logic [ADDR_W:0] sum;
    sum = {1'b0, ptr} + inc;
    if (sum > {1'b0, last}) return {1'b1, base};
    return {1'b0, sum[ADDR_W-1:0]};
  endfunction

endpackage

// File: rtl/sdram_wr_fifo.sv
// Sample FIFO with a four-word look-ahead window so a whole burst can be popped in one cycle.
module sdram_wr_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic [2:0]                pop_n_i,
  output burst_t                    peek_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_q, wr_q;
  logic [AW:0]       cnt_q;
  logic              push_ok;

  assign push_ok = push_i & ~full_o;
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      rd_q  <= rd_q + AW'(pop_n_i);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_n_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  for (genvar k = 0; k < BURST_LEN; k++) begin : g_peek
    assign peek_o[k] = mem_q[rd_q + AW'(k)];
  end

endmodule

// File: rtl/sdram_burst_writer.sv
// Packs a 16-bit sample stream into four-word SDRAM writes on a circular address ring.
// Optional SDRAM_WR_STATS_EN adds burst and stall counters.
module sdram_burst_writer
  import sdram_pkg::*;
#(
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 24'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              i_flush,
  output logic              o_flush_done,
  output logic              o_mode,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data1,
  output logic [DATA_W-1:0] o_data2,
  output logic [DATA_W-1:0] o_data3,
  output logic [DATA_W-1:0] o_data4,
  output logic [1:0]        o_req,
  input  logic [1:0]        i_done,
  output logic [ADDR_W-1:0] o_wr_ptr,
  output logic              o_wrapped
`ifdef SDRAM_WR_STATS_EN
  ,
  output logic [31:0]       o_burst_cnt,
  output logic [31:0]       o_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wr_state_e         state_q, state_d;
  logic [1:0]        req_q, req_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  burst_t            data_q, data_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wrapped_q, wrapped_d;
  logic              flushing_q, flushing_d;

  logic [2:0]        pop_n;
  burst_t            peek;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic [ADDR_W:0]   nxt;
  logic [1:0]        pad;
  logic              unused_done0;

  assign unused_done0 = i_done[0];
  assign s_ready      = ~full & ~flushing_q & ~rst;

  sdram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s_valid & s_ready),
    .wdata_i (s_data),
    .pop_n_i (pop_n),
    .peek_o  (peek),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= REQ_NONE;
      mode_q     <= MODE_SINGLE;
      addr_q     <= BASE_ADDR;
      data_q     <= '0;
      ptr_q      <= BASE_ADDR;
      wrapped_q  <= 1'b0;
      flushing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ptr_q      <= ptr_d;
      wrapped_q  <= wrapped_d;
      flushing_q <= flushing_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ptr_d      = ptr_q;
    wrapped_d  = wrapped_q;
    flushing_d = flushing_q | i_flush;
    pop_n      = 3'd0;
    nxt        = '0;
    pad        = 2'd0;
    unique case (state_q)
      ST_IDLE: begin
        // Complete groups always drain before any flush leftovers.
        if (count >= CW'(BURST_LEN)) begin
          pop_n   = 3'd4;
          data_d  = peek;
          mode_d  = MODE_BURST;
          addr_d  = ptr_q;
          req_d   = REQ_WRITE;
          state_d = ST_BURST;
        end else if (flushing_q && !empty) begin
          pop_n     = 3'd1;
          data_d    = '0;
          data_d[0] = peek[0];
          mode_d    = MODE_SINGLE;
          addr_d    = ptr_q;
          req_d     = REQ_WRITE;
          state_d   = ST_SINGLE;
        end else if (flushing_q) begin
          state_d = ST_FDONE;
        end
      end
      ST_BURST, ST_SINGLE: begin
        if (i_done[1]) begin
          nxt       = ptr_add(ptr_q, (state_q == ST_BURST) ? 25'd4 : 25'd1, BASE_ADDR, END_ADDR);
          ptr_d     = nxt[ADDR_W-1:0];
          wrapped_d = wrapped_q | nxt[ADDR_W];
          req_d     = REQ_NONE;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: state_d = ST_IDLE;
      ST_FDONE: begin
        // Skip the unwritten tail of a partial group so the next burst stays aligned.
        pad        = 2'd0 - ptr_q[1:0];
        nxt        = ptr_add(ptr_q, {23'd0, pad}, BASE_ADDR, END_ADDR);
        ptr_d      = nxt[ADDR_W-1:0];
        wrapped_d  = wrapped_q | nxt[ADDR_W];
        flushing_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_flush_done = (state_q == ST_FDONE);
  assign o_req        = req_q;
  assign o_mode       = mode_q;
  assign o_addr       = addr_q;
  assign o_data1      = data_q[0];
  assign o_data2      = data_q[1];
  assign o_data3      = data_q[2];
  assign o_data4      = data_q[3];
  assign o_wr_ptr     = ptr_q;
  assign o_wrapped    = wrapped_q;

`ifdef SDRAM_WR_STATS_EN
  logic [31:0] burst_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == ST_BURST && i_done[1]) burst_cnt_q <= burst_cnt_q + 32'd1;
      if (s_valid && !s_ready)              stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_burst_cnt = burst_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Directed bench: cycle table for a single burst, then sequences for flush, wrap, backpressure, reset.
module tb_sdram_burst_writer;

  localparam logic [23:0] BASE = 24'h000100;
  localparam logic [23:0] END1 = 24'h0003FF;
  localparam logic [23:0] END2 = 24'h000107;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic        auto_done = 1'b0;
  logic [1:0]  man_done = 2'b00;
  logic [1:0]  resp_done = 2'b00;
  logic [1:0]  i_done;

  logic        rdy1, fd1, mode1, wr1, rdy2, fd2, mode2, wr2;
  logic [1:0]  req1, req2;
  logic [23:0] addr1, ptr1, addr2, ptr2;
  logic [15:0] d11, d12, d13, d14, d21, d22, d23, d24;
`ifdef SDRAM_WR_STATS_EN
  logic [31:0] bc1, sc1, bc2, sc2;
`endif

  assign i_done = auto_done ? resp_done : man_done;

  always #5 clk = ~clk;

  sdram_burst_writer #(.FIFO_DEPTH(8), .BASE_ADDR(BASE), .END_ADDR(END1)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy1),
    .i_flush(i_flush), .o_flush_done(fd1), .o_mode(mode1), .o_addr(addr1),
    .o_data1(d11), .o_data2(d12), .o_data3(d13), .o_data4(d14),
    .o_req(req1), .i_done(i_done), .o_wr_ptr(ptr1), .o_wrapped(wr1)
`ifdef SDRAM_WR_STATS_EN
    , .o_burst_cnt(bc1), .o_stall_cnt(sc1)
`endif
  );

  // Small ring: eight words, so the third burst wraps back to BASE.
  sdram_burst_writer #(.FIFO_DEPTH(8), .BASE_ADDR(BASE), .END_ADDR(END2)) dut2 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy2),
    .i_flush(i_flush), .o_flush_done(fd2), .o_mode(mode2), .o_addr(addr2),
    .o_data1(d21), .o_data2(d22), .o_data3(d23), .o_data4(d24),
    .o_req(req2), .i_done(i_done), .o_wr_ptr(ptr2), .o_wrapped(wr2)
`ifdef SDRAM_WR_STATS_EN
    , .o_burst_cnt(bc2), .o_stall_cnt(sc2)
`endif
  );

  int total = 0;
  int passed = 0;
  int fd_cnt = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  typedef struct packed {
    logic        mode;
    logic [23:0] a1;
    logic [23:0] a2;
    logic        w2;
    logic [63:0] dat;
  } wr_t;
  wr_t log_q[$];

  always @(posedge clk) if (fd1) fd_cnt <= fd_cnt + 1;

  // SDRAM model: acknowledges each write on its second request cycle and logs what was written.
  initial begin
    int wcnt;
    wr_t e;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (!auto_done || rst) begin
        resp_done = 2'b00;
        wcnt = 0;
      end else if (req1 == 2'b10 && resp_done == 2'b00) begin
        wcnt++;
        if (wcnt >= 2) begin
          resp_done = 2'b10;
          wcnt = 0;
          e.mode = mode1; e.a1 = addr1; e.a2 = addr2; e.w2 = wr2;
          e.dat = {d11, d12, d13, d14};
          log_q.push_back(e);
        end
      end else begin
        resp_done = 2'b00;
      end
    end
  end

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic [1:0]  done;
    logic        rdy;
    logic [1:0]  req;
    logic        mode;
    logic [23:0] addr;
    logic [23:0] ptr;
    logic [15:0] d1;
    logic [15:0] d4;
  } vec_t;

  function automatic vec_t mkv(input logic v, input logic [15:0] d, input logic [1:0] done,
                               input logic rdy, input logic [1:0] req, input logic mode,
                               input logic [23:0] addr, input logic [23:0] ptr,
                               input logic [15:0] d1, input logic [15:0] d4);
    vec_t r;
    r.v = v; r.d = d; r.done = done; r.rdy = rdy; r.req = req; r.mode = mode;
    r.addr = addr; r.ptr = ptr; r.d1 = d1; r.d4 = d4;
    return r;
  endfunction

  task automatic push(input logic [15:0] w);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = w;
    #1;
    while (!rdy1 && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (!rdy1) begin
      total++;
      $display("FAIL push_timeout: sample %h never accepted", w);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_log(input string name, input int k);
    int n;
    n = 0;
    while (log_q.size() < k && n < 300) begin
      @(negedge clk); n++;
    end
    chk(name, log_q.size(), k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; i_flush = 1'b0; man_done = 2'b00; auto_done = 1'b0;
    log_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[13];

  initial begin : main
    int fd0, seen, reqseen, n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fd0, seen, reqseen, n;
    logic [63:0] expd;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", rdy1, 0);
    chk("rst_req", req1, 0);
    chk("rst_mode", mode1, 0);
    chk("rst_addr", addr1, BASE);
    chk("rst_ptr", ptr1, BASE);
    chk("rst_data", {d11, d12, d13, d14}, 0);
    chk("rst_wrapped_fd", {wr1, fd1}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: single burst, cycle by cycle
    tbl[0]  = mkv(1, 16'h0001, 2'b00, 1, 2'b00, 0, BASE, BASE, 16'h0, 16'h0);
    tbl[1]  = mkv(1, 16'h0002, 2'b00, 1, 2'b00, 0, BASE, BASE, 16'h0, 16'h0);
    tbl[2]  = mkv(1, 16'h0003, 2'b00, 1, 2'b00, 0, BASE, BASE, 16'h0, 16'h0);
    tbl[3]  = mkv(1, 16'h0004, 2'b00, 1, 2'b00, 0, BASE, BASE, 16'h0, 16'h0);
    tbl[4]  = mkv(0, 16'h0000, 2'b00, 1, 2'b00, 0, BASE, BASE, 16'h0, 16'h0);
    tbl[5]  = mkv(0, 16'h0000, 2'b00, 1, 2'b10, 1, BASE, BASE, 16'h1, 16'h4);
    tbl[6]  = mkv(0, 16'h0000, 2'b01, 1, 2'b10, 1, BASE, BASE, 16'h1, 16'h4);
    tbl[7]  = mkv(0, 16'h0000, 2'b00, 1, 2'b10, 1, BASE, BASE, 16'h1, 16'h4);
    tbl[8]  = mkv(0, 16'h0000, 2'b00, 1, 2'b10, 1, BASE, BASE, 16'h1, 16'h4);
    tbl[9]  = mkv(0, 16'h0000, 2'b10, 1, 2'b10, 1, BASE, BASE, 16'h1, 16'h4);
    tbl[10] = mkv(0, 16'h0000, 2'b00, 1, 2'b00, 1, BASE, BASE + 24'd4, 16'h1, 16'h4);
    tbl[11] = mkv(0, 16'h0000, 2'b10, 1, 2'b00, 1, BASE, BASE + 24'd4, 16'h1, 16'h4);
    tbl[12] = mkv(0, 16'h0000, 2'b00, 1, 2'b00, 1, BASE, BASE + 24'd4, 16'h1, 16'h4);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      s_valid  = tbl[i].v;
      s_data   = tbl[i].d;
      man_done = tbl[i].done;
      #1;
      chk($sformatf("t1_row%0d {rdy,req,mode,addr,ptr,d1,d4}", i),
          {rdy1, req1, mode1, addr1, ptr1, d11, d14},
          {tbl[i].rdy, tbl[i].req, tbl[i].mode, tbl[i].addr, tbl[i].ptr, tbl[i].d1, tbl[i].d4});
    end
    man_done = 2'b00;

    // Test 2: six samples then flush
    do_reset();
    auto_done = 1'b1;
    for (int i = 0; i < 6; i++) push(16'h0010 + 16'(i));
    i_flush = 1'b1;
    fd0 = fd_cnt;
    @(negedge clk);
    i_flush = 1'b0;
    n = 0;
    while (fd_cnt == fd0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #1;
    chk("t2_flush_pulses", fd_cnt - fd0, 1);
    chk("t2_writes", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t2_burst", {log_q[0].mode, log_q[0].a1, log_q[0].dat},
          {1'b1, BASE, 64'h0010_0011_0012_0013});
      chk("t2_single0", {log_q[1].mode, log_q[1].a1, log_q[1].dat[63:48]},
          {1'b0, BASE + 24'd4, 16'h0014});
      chk("t2_single1", {log_q[2].mode, log_q[2].a1, log_q[2].dat[63:48]},
          {1'b0, BASE + 24'd5, 16'h0015});
    end
    chk("t2_ptr", ptr1, BASE + 24'd8);
    chk("t2_ready_after", rdy1, 1);

    // Test 3: ring wrap on the eight-word instance
    do_reset();
    auto_done = 1'b1;
    for (int i = 0; i < 12; i++) push(16'h0030 + 16'(i));
    wait_log("t3_writes", 3);
    repeat (3) @(negedge clk);
    #1;
    if (log_q.size() >= 3) begin
      chk("t3_addrs_small", {log_q[0].a2, log_q[1].a2, log_q[2].a2}, {BASE, BASE + 24'd4, BASE});
      chk("t3_addrs_big", {log_q[0].a1, log_q[1].a1, log_q[2].a1},
          {BASE, BASE + 24'd4, BASE + 24'd8});
      chk("t3_wrapped_before_2nd_done", log_q[1].w2, 0);
      chk("t3_wrapped_after_2nd_done", log_q[2].w2, 1);
      chk("t3_data3", log_q[2].dat, 64'h0038_0039_003A_003B);
    end
    chk("t3_wrapped_final", {wr2, wr1}, 2'b10);
    chk("t3_ptrs", {ptr2, ptr1}, {BASE + 24'd4, BASE + 24'd12});

    // Test 4: stalled SDRAM, FIFO fills, then drains with no loss
    do_reset();
    fork
      begin
        for (int i = 0; i < 20; i++) push(16'h0200 + 16'(i));
      end
      begin
        repeat (30) @(negedge clk);
        #1;
        chk("t4_ready_low_when_full", rdy1, 0);
        chk("t4_req_held", req1, 2'b10);
        chk("t4_no_writes_yet", log_q.size(), 0);
        auto_done = 1'b1;
      end
    join
    wait_log("t4_writes", 5);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k < log_q.size()) begin
        expd = {16'h0200 + 16'(4*k), 16'h0201 + 16'(4*k), 16'h0202 + 16'(4*k), 16'h0203 + 16'(4*k)};
        chk($sformatf("t4_burst%0d", k), {log_q[k].a1, log_q[k].dat}, {BASE + 24'(4*k), expd});
      end
    end
    chk("t4_ptr", ptr1, BASE + 24'd20);

    // Test 5: reset while a write request is held
    do_reset();
    auto_done = 1'b1;
    for (int i = 0; i < 4; i++) push(16'h0050 + 16'(i));
    wait_log("t5_first_write", 1);
    repeat (3) @(negedge clk);
    auto_done = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h0060 + 16'(i));
    n = 0;
    #1;
    while (req1 != 2'b10 && n < 20) begin @(negedge clk); #1; n++; end
    chk("t5_req_before", {req1, ptr1}, {2'b10, BASE + 24'd4});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_ready_in_reset", rdy1, 0);
    @(negedge clk);
    #1;
    chk("t5_after_reset", {req1, ptr1, addr1, rdy1}, {2'b00, BASE, BASE, 1'b0});
    rst = 1'b0;

    // Test 6: flush with an empty FIFO
    do_reset();
    fd0 = fd_cnt;
    seen = 0;
    reqseen = 0;
    @(negedge clk);
    i_flush = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      i_flush = 1'b0;
      #1;
      if (fd1) seen = 1;
      if (req1 != 2'b00) reqseen = 1;
    end
    chk("t6_flush_done_within_2", seen, 1);
    repeat (3) @(negedge clk);
    #1;
    if (req1 != 2'b00) reqseen = 1;
    chk("t6_flush_pulses", fd_cnt - fd0, 1);
    chk("t6_no_req", reqseen, 0);
    chk("t6_ptr_unchanged", ptr1, BASE);
    chk("t6_ready_after", rdy1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
